// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
// Contents: data width, register address width, register count,
//           round-robin priority encoding, tracked-register helper.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Which requester wins when both are valid in the same cycle.
  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_t;

  // x0 is architecturally constant, so it is never written and never tracked.
  function automatic logic is_tracked(input logic [REG_ADDR_W-1:0] addr);
    return (addr != '0);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter for the writeback port.
// Latency: grant is combinational from req; the priority pointer moves at the edge.
// Backpressure: hold=1 forces an empty grant and freezes the pointer.
// Ports: clock, reset (sync, active-high), req[1:0], hold, grant[1:0] (one-hot or zero).
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] grant
);

  prio_t prio_q;

  always_comb begin
    grant = 2'b00;
    if (!hold) begin
      if (req == 2'b11) begin
        grant = (prio_q == PRIO_REQ0) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  // A grant always completes a transfer (ready is only driven with valid),
  // so a non-empty grant is the accept condition for the pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q <= PRIO_REQ0;
    end else if (grant[0]) begin
      prio_q <= PRIO_REQ1;
    end else if (grant[1]) begin
      prio_q <= PRIO_REQ0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard in front of a register file.
// Latency: accepted writeback drives the register file write port one cycle later.
// Backpressure: reqN_ready only for the arbitration winner; issue_ready drops on a pending rd.
// Ports: clock/reset; req0_* (ALU) and req1_* (load) valid/ready/rd/data;
//        issue_valid/issue_ready/issue_rd; rs1_sel/rs2_sel -> hazard;
//        WR_EN/write_select/data_in to the register file write port.
module regfile_wb_arbiter #(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                              clock,
  input  logic                              reset,

  input  logic                              req0_valid,
  output logic                              req0_ready,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] req0_rd,
  input  logic [XLEN-1:0]                   req0_data,

  input  logic                              req1_valid,
  output logic                              req1_ready,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] req1_rd,
  input  logic [XLEN-1:0]                   req1_data,

  input  logic                              issue_valid,
  output logic                              issue_ready,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] issue_rd,

  input  logic [regfile_pkg::REG_ADDR_W-1:0] rs1_sel,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] rs2_sel,
  output logic                              hazard,

  output logic                              WR_EN,
  output logic [regfile_pkg::REG_ADDR_W-1:0] write_select,
  output logic [XLEN-1:0]                   data_in
);

  localparam int AW = regfile_pkg::REG_ADDR_W;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [1:0]      grant;
  logic            xfer;
  logic [AW-1:0]   xfer_rd;
  logic [XLEN-1:0] xfer_data;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .hold  (reset),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;
  assign xfer_rd    = grant[1] ? req1_rd   : req0_rd;
  assign xfer_data  = grant[1] ? req1_data : req0_data;

  // ---------------------------------------------------------------------
  // Register file write port
  // ---------------------------------------------------------------------
  logic            wr_en_q;
  logic [AW-1:0]   sel_q;
  logic [XLEN-1:0] data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_q <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      wr_en_q <= xfer && regfile_pkg::is_tracked(xfer_rd);
      if (xfer) begin
        sel_q  <= xfer_rd;
        data_q <= xfer_data;
      end
    end
  end

  // A write that was accepted just before reset must not land in the
  // register file while reset is held.
  assign WR_EN        = wr_en_q & ~reset;
  assign write_select = sel_q;
  assign data_in      = data_q;

  // ---------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                issue_set;

  assign issue_ready = ~reset & ~(regfile_pkg::is_tracked(issue_rd) & pending[issue_rd]);
  assign issue_set   = issue_valid & issue_ready & regfile_pkg::is_tracked(issue_rd);

  // Clear first, then set: a new reservation made on the same edge as the
  // old value commits must survive.
  always_comb begin
    pending_nxt = pending;
    if (WR_EN) begin
      pending_nxt[write_select] = 1'b0;
    end
    if (issue_set) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign hazard = (regfile_pkg::is_tracked(rs1_sel) & pending[rs1_sel]) |
                  (regfile_pkg::is_tracked(rs2_sel) & pending[rs2_sel]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  req0_rd = '0, req1_rd = '0, issue_rd = '0, rs1_sel = '0, rs2_sel = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, issue_ready, hazard, WR_EN;
  logic [4:0]  write_select;
  logic [31:0] data_in;

  always #5 clock = ~clock;

  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .hazard(hazard),
    .WR_EN(WR_EN), .write_select(write_select), .data_in(data_in)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        v0;  logic [4:0] rd0; logic [31:0] d0;
    logic        v1;  logic [4:0] rd1; logic [31:0] d1;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        e_r0, e_r1, e_ir, e_hz, e_wr, e_sd;
    logic [4:0]  e_sel; logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(
      input logic rst,
      input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
      input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
      input logic iv, input logic [4:0] ird,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic e_r0, input logic e_r1, input logic e_ir, input logic e_hz,
      input logic e_wr, input logic e_sd, input logic [4:0] e_sel, input logic [31:0] e_dat);
    vec_t r;
    r.rst = rst; r.v0 = v0; r.rd0 = rd0; r.d0 = d0; r.v1 = v1; r.rd1 = rd1; r.d1 = d1;
    r.iv = iv; r.ird = ird; r.rs1 = rs1; r.rs2 = rs2;
    r.e_r0 = e_r0; r.e_r1 = e_r1; r.e_ir = e_ir; r.e_hz = e_hz;
    r.e_wr = e_wr; r.e_sd = e_sd; r.e_sel = e_sel; r.e_dat = e_dat;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic iv, input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2);
    reset = rst;
    req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    issue_valid = iv; issue_rd = ird; rs1_sel = rs1; rs2_sel = rs2;
  endtask

  // Behavioural reference model state
  bit          pend[32];
  int          last_g;
  bit          m_wr;
  logic [4:0]  m_sel;
  logic [31:0] m_dat;

  initial begin
    //          rst v0 rd0 d0            v1 rd1 d1            iv ird rs1 rs2  r0 r1 ir hz wr sd sel dat
    tbl.push_back(row(1, 0, 0, 0,            0, 0, 0,            0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  0));
    tbl.push_back(row(0, 1, 16, 32'hAAAAAAAA, 0, 0, 0,           0, 0,  0,  0,  1, 0, 1, 0, 0, 1, 0,  0));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  0,  0,  0, 0, 1, 0, 1, 1, 16, 32'hAAAAAAAA));
    tbl.push_back(row(1, 0, 0, 0,            0, 0, 0,            0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  0));
    tbl.push_back(row(0, 1, 5, 32'h55,       1, 6, 32'h66,       0, 0,  0,  0,  1, 0, 1, 0, 0, 1, 0,  0));
    tbl.push_back(row(0, 1, 5, 32'h55,       1, 6, 32'h66,       0, 0,  0,  0,  0, 1, 1, 0, 1, 1, 5,  32'h55));
    tbl.push_back(row(0, 1, 5, 32'h55,       1, 6, 32'h66,       0, 0,  0,  0,  1, 0, 1, 0, 1, 1, 6,  32'h66));
    tbl.push_back(row(0, 1, 5, 32'h55,       1, 6, 32'h66,       0, 0,  0,  0,  0, 1, 1, 0, 1, 1, 5,  32'h55));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  0,  0,  0, 0, 1, 0, 1, 1, 6,  32'h66));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  0,  0,  0, 0, 1, 0, 0, 1, 6,  32'h66));
    tbl.push_back(row(0, 0, 0, 0,            1, 0, 32'hCCCCCCCC, 0, 0,  0,  0,  0, 1, 1, 0, 0, 1, 6,  32'h66));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  0,  0,  0, 0, 1, 0, 0, 0, 0,  0));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            1, 17, 17, 0,  0, 0, 1, 0, 0, 0, 0,  0));
    tbl.push_back(row(0, 1, 17, 32'hBBBBBBBB, 0, 0, 0,           1, 17, 17, 0,  1, 0, 0, 1, 0, 0, 0,  0));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  17, 0,  0, 0, 1, 1, 1, 1, 17, 32'hBBBBBBBB));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  17, 0,  0, 0, 1, 0, 0, 1, 17, 32'hBBBBBBBB));
    tbl.push_back(row(0, 1, 9, 32'h99,       0, 0, 0,            0, 0,  0,  0,  1, 0, 1, 0, 0, 0, 0,  0));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            1, 9,  0,  9,  0, 0, 1, 0, 1, 1, 9,  32'h99));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            1, 9,  0,  9,  0, 0, 0, 1, 0, 0, 0,  0));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  0,  9,  0, 0, 1, 1, 0, 0, 0,  0));
    tbl.push_back(row(0, 1, 3, 32'h33,       1, 4, 32'h44,       0, 0,  0,  9,  0, 1, 1, 1, 0, 0, 0,  0));
    tbl.push_back(row(1, 1, 3, 32'h33,       1, 4, 32'h44,       0, 0,  0,  9,  0, 0, 0, 1, 0, 0, 0,  0));
    tbl.push_back(row(0, 1, 3, 32'h33,       1, 4, 32'h44,       0, 0,  0,  9,  1, 0, 1, 0, 0, 1, 0,  0));
    tbl.push_back(row(0, 1, 3, 32'h33,       1, 4, 32'h44,       0, 0,  0,  9,  0, 1, 1, 0, 1, 1, 3,  32'h33));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  0,  0,  0, 0, 1, 0, 1, 1, 4,  32'h44));
    tbl.push_back(row(0, 0, 0, 0,            0, 0, 0,            0, 0,  0,  0,  0, 0, 1, 0, 0, 1, 4,  32'h44));

    // First edge at t=5 samples reset=1; table rows start after it.
    @(posedge clock); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1,
            tbl[i].iv, tbl[i].ird, tbl[i].rs1, tbl[i].rs2);
      @(negedge clock);
      chk($sformatf("row%0d req0_ready", i), req0_ready, tbl[i].e_r0);
      chk($sformatf("row%0d req1_ready", i), req1_ready, tbl[i].e_r1);
      chk($sformatf("row%0d issue_ready", i), issue_ready, tbl[i].e_ir);
      chk($sformatf("row%0d hazard", i), hazard, tbl[i].e_hz);
      chk($sformatf("row%0d WR_EN", i), WR_EN, tbl[i].e_wr);
      if (tbl[i].e_sd) begin
        chk($sformatf("row%0d write_select", i), write_select, tbl[i].e_sel);
        chk($sformatf("row%0d data_in", i), data_in, tbl[i].e_dat);
      end
      @(posedge clock); #1;
    end

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 3000; n++) begin
      logic rst_r, v0_r, v1_r, iv_r;
      logic [4:0] rd0_r, rd1_r, ird_r, rs1_r, rs2_r;
      int win;
      bit e_ir, e_hz;
      rst_r = (n == 0) || ($urandom_range(0, 63) == 0);
      v0_r  = $urandom_range(0, 1);
      v1_r  = $urandom_range(0, 1);
      iv_r  = $urandom_range(0, 1);
      rd0_r = 5'($urandom_range(0, 7));
      rd1_r = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ird_r = 5'($urandom_range(0, 7));
      rs1_r = 5'($urandom_range(0, 7));
      rs2_r = 5'($urandom_range(0, 7));
      drive(rst_r, v0_r, rd0_r, $urandom, v1_r, rd1_r, $urandom, iv_r, ird_r, rs1_r, rs2_r);
      @(negedge clock);

      win = -1;
      if (!rst_r) begin
        if (v0_r && v1_r) win = (last_g == 0) ? 1 : 0;
        else if (v0_r)    win = 0;
        else if (v1_r)    win = 1;
      end
      e_ir = !rst_r && !(ird_r != 0 && pend[ird_r]);
      e_hz = (rs1_r != 0 && pend[rs1_r]) || (rs2_r != 0 && pend[rs2_r]);

      if (n > 0) begin
        chk("rnd req0_ready", req0_ready, (win == 0));
        chk("rnd req1_ready", req1_ready, (win == 1));
        chk("rnd issue_ready", issue_ready, e_ir);
        chk("rnd hazard", hazard, e_hz);
        chk("rnd WR_EN", WR_EN, m_wr && !rst_r);
        chk("rnd write_select", write_select, m_sel);
        chk("rnd data_in", data_in, m_dat);
      end

      if (rst_r) begin
        foreach (pend[k]) pend[k] = 0;
        last_g = 1;
        m_wr = 0; m_sel = '0; m_dat = '0;
      end else begin
        if (m_wr) pend[m_sel] = 0;
        if (iv_r && e_ir && ird_r != 0) pend[ird_r] = 1;
        if (win >= 0) begin
          m_wr   = (win == 0) ? (rd0_r != 0) : (rd1_r != 0);
          m_sel  = (win == 0) ? rd0_r : rd1_r;
          m_dat  = (win == 0) ? req0_data : req1_data;
          last_g = win;
        end else begin
          m_wr = 0;
        end
      end
      @(posedge clock); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
